// File: rtl/cpu6_dec_stage.sv
// Decode stage: opcode classification, immediate generation and a 2-entry
// skid buffer between fetch and execute, adding one cycle of latency.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_BRANCHTYPE_SIZE
`define CPU6_BRANCHTYPE_SIZE 3
`endif

module cpu6_immdec #(
  parameter int XLEN = `CPU6_XLEN,
  parameter int BT   = `CPU6_BRANCHTYPE_SIZE
) (
  input  logic [31:7]     instr,
  input  logic [BT-1:0]   immtype,
  output logic [XLEN-1:0] imm
);
  localparam logic [BT-1:0] IMM_I = BT'(3'd0);
  localparam logic [BT-1:0] IMM_S = BT'(3'd1);
  localparam logic [BT-1:0] IMM_B = BT'(3'd2);
  localparam logic [BT-1:0] IMM_U = BT'(3'd3);

  logic [31:0] imm32;

  // Immediate assembly for the I/S/B/U formats; any other type yields zero
  always_comb begin
    imm32 = 32'd0;
    case (immtype)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'd0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
endmodule

module cpu6_dec_stage #(
  parameter int XLEN = `CPU6_XLEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             ifu_valid,
  input  logic [XLEN-1:0]                  ifu_instr,
  input  logic [XLEN-1:0]                  ifu_pc,
  output logic                             ifu_ready,
  output logic                             dec_valid,
  input  logic                             dec_ready,
  output logic [XLEN-1:0]                  dec_instr,
  output logic [XLEN-1:0]                  dec_pc,
  output logic [`CPU6_BRANCHTYPE_SIZE-1:0] dec_immtype,
  output logic [XLEN-1:0]                  dec_imm,
  output logic                             dec_illegal
);
  localparam int BT = `CPU6_BRANCHTYPE_SIZE;
  localparam logic [BT-1:0] IMM_I    = BT'(3'd0);
  localparam logic [BT-1:0] IMM_S    = BT'(3'd1);
  localparam logic [BT-1:0] IMM_B    = BT'(3'd2);
  localparam logic [BT-1:0] IMM_U    = BT'(3'd3);
  localparam logic [BT-1:0] IMM_NONE = BT'(3'd7);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            pop;
  logic            load_new;
  logic            load_skid;
  logic            skid_to_head;

  logic [BT-1:0]   new_immtype;
  logic            new_illegal;
  logic            new_jal;
  logic [XLEN-1:0] immdec_imm;
  logic [31:0]     jal_imm32;
  logic [XLEN-1:0] new_imm;

  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [BT-1:0]   skid_immtype;
  logic [XLEN-1:0] skid_imm;
  logic            skid_illegal;

  // Opcode classification of the incoming fetch word
  always_comb begin
    new_immtype = IMM_NONE;
    new_illegal = 1'b0;
    new_jal     = 1'b0;
    case (ifu_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011: new_immtype = IMM_I;
      7'b0100011:             new_immtype = IMM_S;
      7'b1100011:             new_immtype = IMM_B;
      7'b0110111, 7'b0010111: new_immtype = IMM_U;
      7'b0110011:             new_immtype = IMM_NONE;
      7'b1101111:             new_jal     = 1'b1;
      default:                new_illegal = 1'b1;
    endcase
  end

  cpu6_immdec #(.XLEN(XLEN), .BT(BT)) u_immdec (
    .instr   (ifu_instr[31:7]),
    .immtype (new_immtype),
    .imm     (immdec_imm)
  );

  // J format is absent from immdec, so JAL's offset is assembled here
  assign jal_imm32 = {{12{ifu_instr[31]}}, ifu_instr[19:12], ifu_instr[20],
                      ifu_instr[30:21], 1'b0};
  assign new_imm   = new_jal ? {{(XLEN-31){jal_imm32[31]}}, jal_imm32[30:0]} : immdec_imm;

  assign ifu_ready = (state != TWO) & ~reset;
  assign dec_valid = (state != EMPTY);
  assign accept    = ifu_valid & ifu_ready;
  assign pop       = dec_valid & dec_ready;

  // Buffer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and load controls; flush discards any accept in the same cycle
  always_comb begin
    state_next   = state;
    load_new     = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_new   = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (pop && !accept) begin
            state_next = EMPTY;
          end else if (accept && pop) begin
            state_next = ONE;
            load_new   = 1'b1;
          end else begin
            state_next = ONE;
          end
        end
        TWO: begin
          if (pop) begin
            state_next   = ONE;
            skid_to_head = 1'b1;
          end else begin
            state_next = TWO;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Head (dec_*) and skid entry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_instr    <= '0;
      dec_pc       <= '0;
      dec_immtype  <= IMM_NONE;
      dec_imm      <= '0;
      dec_illegal  <= 1'b0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_immtype <= IMM_NONE;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_new) begin
        dec_instr   <= ifu_instr;
        dec_pc      <= ifu_pc;
        dec_immtype <= new_immtype;
        dec_imm     <= new_imm;
        dec_illegal <= new_illegal;
      end else if (skid_to_head) begin
        dec_instr   <= skid_instr;
        dec_pc      <= skid_pc;
        dec_immtype <= skid_immtype;
        dec_imm     <= skid_imm;
        dec_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_instr   <= ifu_instr;
        skid_pc      <= ifu_pc;
        skid_immtype <= new_immtype;
        skid_imm     <= new_imm;
        skid_illegal <= new_illegal;
      end
    end
  end
endmodule

// File: tb/tb_cpu6_dec_stage.sv
// Randomized and directed bench for cpu6_dec_stage against a queue-based
// FIFO model with an arithmetic immediate reference.
`timescale 1ns/1ps

module tb_cpu6_dec_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_instr = 32'd0;
  logic [31:0] ifu_pc = 32'd0;
  logic        ifu_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  dec_immtype;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  cpu6_dec_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ifu_valid(ifu_valid), .ifu_instr(ifu_instr), .ifu_pc(ifu_pc), .ifu_ready(ifu_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_immtype(dec_immtype), .dec_imm(dec_imm), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t q[$];
  int     errors = 0;
  int     checks = 0;
  logic   after_reset = 1'b0;
  logic [6:0] ops [0:11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h0B};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: immtype codes I=0 S=1 B=2 U=3 NONE=7, offsets as signed sums
  function automatic void ref_decode(input logic [31:0] i, output logic [2:0] t,
                                     output logic [31:0] imm, output logic ill);
    int v;
    int s;
    t = 3'd7; v = 0; ill = 1'b0;
    s = i[31] ? 1 : 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin t = 3'd0; v = -2048*s + int'(i[30:20]); end
      7'h23: begin t = 3'd1; v = -2048*s + 32*int'(i[30:25]) + int'(i[11:7]); end
      7'h63: begin t = 3'd2; v = -4096*s + 2048*int'(i[7]) + 32*int'(i[30:25]) + 2*int'(i[11:8]); end
      7'h37, 7'h17: begin t = 3'd3; v = int'(i & 32'hFFFFF000); end
      7'h33: v = 0;
      7'h6F: v = -1048576*s + 4096*int'(i[19:12]) + 2048*int'(i[20]) + 2*int'(i[30:21]);
      default: ill = 1'b1;
    endcase
    imm = 32'(v);
  endfunction

  task automatic compare();
    logic [2:0]  t;
    logic [31:0] im;
    logic        il;
    check_eq("dec_valid", 64'(dec_valid), 64'(q.size() > 0));
    check_eq("ifu_ready", 64'(ifu_ready), 64'(!reset && q.size() < 2));
    if (q.size() > 0) begin
      ref_decode(q[0].instr, t, im, il);
      check_eq("dec_instr", 64'(dec_instr), 64'(q[0].instr));
      check_eq("dec_pc", 64'(dec_pc), 64'(q[0].pc));
      check_eq("dec_immtype", 64'(dec_immtype), 64'(t));
      check_eq("dec_imm", 64'(dec_imm), 64'(im));
      check_eq("dec_illegal", 64'(dec_illegal), 64'(il));
    end else if (after_reset) begin
      check_eq("rst_instr", 64'(dec_instr), 64'd0);
      check_eq("rst_pc", 64'(dec_pc), 64'd0);
      check_eq("rst_immtype", 64'(dec_immtype), 64'd7);
      check_eq("rst_imm", 64'(dec_imm), 64'd0);
      check_eq("rst_illegal", 64'(dec_illegal), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic dr, input logic fl, input logic rs);
    logic acc;
    logic pp;
    entry_t e;
    ifu_valid = v; ifu_instr = ins; ifu_pc = p; dec_ready = dr; flush = fl; reset = rs;
    acc = v && !rs && (q.size() < 2);
    pp  = dr && (q.size() > 0);
    e.instr = ins; e.pc = p;
    @(posedge clk);
    if (rs) begin
      q.delete();
      after_reset = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        after_reset = 1'b0;
      end
    end
    #1;
    compare();
  endtask

  initial begin
    logic [31:0] r;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 32'h4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // addi x1,x0,-1
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, 1'b0);
    check_eq("t1_imm", 64'(dec_imm), 64'hFFFFFFFF);
    check_eq("t1_type", 64'(dec_immtype), 64'd0);
    check_eq("t1_ill", 64'(dec_illegal), 64'd0);

    // back-to-back sw, beq, lui, jal
    step(1'b1, 32'h00112623, 32'h104, 1'b1, 1'b0, 1'b0);
    check_eq("t2_sw_imm", 64'({dec_immtype, dec_imm}), {29'd0, 3'd1, 32'h0000000C});
    step(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0, 1'b0);
    check_eq("t2_beq_imm", 64'({dec_immtype, dec_imm}), {29'd0, 3'd2, 32'hFFFFFFFC});
    step(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0, 1'b0);
    check_eq("t2_lui_imm", 64'({dec_immtype, dec_imm}), {29'd0, 3'd3, 32'h12345000});
    step(1'b1, 32'h0080006F, 32'h110, 1'b1, 1'b0, 1'b0);
    check_eq("t2_jal_imm", 64'({dec_immtype, dec_imm}), {29'd0, 3'd7, 32'h00000008});
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // backpressure: A,B accepted, C held until the buffer drains
    step(1'b1, 32'h00A00093, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00B00113, 32'h204, 1'b0, 1'b0, 1'b0);
    check_eq("t3_ready_full", 64'(ifu_ready), 64'd0);
    step(1'b1, 32'h00C00193, 32'h208, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 32'h00C00193, 32'h208, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // flush in state TWO with a live offer
    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0037, 32'h308, 1'b1, 1'b1, 1'b0);
    check_eq("t4_valid", 64'(dec_valid), 64'd0);
    check_eq("t4_ready", 64'(ifu_ready), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // illegal encodings and plain OP
    step(1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0, 1'b0);
    check_eq("t5_zero_ill", 64'({dec_illegal, dec_imm}), {31'd0, 1'b1, 32'd0});
    step(1'b1, 32'hFFFFFFFF, 32'h404, 1'b1, 1'b0, 1'b0);
    check_eq("t5_ones_ill", 64'({dec_illegal, dec_imm}), {31'd0, 1'b1, 32'd0});
    step(1'b1, 32'h00B50533, 32'h408, 1'b1, 1'b0, 1'b0);
    check_eq("t5_add", 64'({dec_illegal, dec_immtype, dec_imm}), {28'd0, 1'b0, 3'd7, 32'd0});

    // reset with the buffer full, then resume
    step(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 32'h504, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00700093, 32'h508, 1'b0, 1'b0, 1'b1);
    check_eq("t6_valid", 64'(dec_valid), 64'd0);
    step(1'b1, 32'h00800093, 32'h50C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) r[6:0] = 7'($urandom());
      else r[6:0] = ops[$urandom_range(0, 11)];
      step(1'($urandom_range(0, 3) != 0), r, $urandom(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
